// File: rtl/prog_sequencer.sv
// Program store and fetch/issue sequencer for the 4-bit microcode processor.
// Captures the host instruction stream, then steps through it issuing to the datapath.
module prog_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               state,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr,
  input  logic               z_flag,
  input  logic               ex_ready,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    prog_len,
  output logic               running,
  output logic               halted,
  output logic               load_ovf,
  output logic               bad_jump
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HALT
  } st_e;

  st_e                st_q;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] ir_q;
  logic               ir_valid_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W:0]    len_q;
  logic               ovf_q;
  logic               bj_q;

  logic               full;
  logic               is_jnz;
  logic [ADDR_W-1:0]  tgt;
  logic               tgt_bad;
  logic [ADDR_W:0]    pc_inc;
  logic               last;
  logic [ADDR_W-1:0]  adv_pc;
  st_e                adv_st;

  // len_q never exceeds DEPTH, so its top bit alone flags a full store
  assign full    = len_q[ADDR_W];
  assign is_jnz  = (ir_q[7:4] == 4'h3);
  assign tgt     = ADDR_W'(ir_q[3:0]);
  assign tgt_bad = ({1'b0, tgt} >= len_q);
  assign pc_inc  = {1'b0, pc_q} + ONE;
  assign last    = (pc_inc == len_q);
  assign adv_pc  = last ? pc_q : pc_inc[ADDR_W-1:0];
  assign adv_st  = last ? S_HALT : S_FETCH;

  always_ff @(posedge clk) begin
    if (rst && st_q == S_LOAD && !state && load && !full)
      mem_q[len_q[ADDR_W-1:0]] <= instr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q       <= S_LOAD;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pc_q       <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      bj_q       <= 1'b0;
    end else if (st_q != S_LOAD && !state) begin
      // abort beats any same-edge acceptance; pc is left untouched
      st_q       <= S_LOAD;
      ir_valid_q <= 1'b0;
      len_q      <= '0;
    end else begin
      unique case (st_q)
        S_LOAD: begin
          if (state) begin
            pc_q <= '0;
            st_q <= (len_q == '0) ? S_HALT : S_FETCH;
          end else if (load) begin
            if (full) ovf_q <= 1'b1;
            else      len_q <= len_q + ONE;
          end
        end
        S_FETCH: begin
          ir_q <= mem_q[pc_q];
          st_q <= S_DECODE;
        end
        S_DECODE: begin
          if (is_jnz && !z_flag) begin
            pc_q <= tgt;
            if (tgt_bad) begin
              st_q <= S_HALT;
              bj_q <= 1'b1;
            end else begin
              st_q <= S_FETCH;
            end
          end else if (is_jnz) begin
            pc_q <= adv_pc;
            st_q <= adv_st;
          end else begin
            ir_valid_q <= 1'b1;
            st_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ex_ready) begin
            ir_valid_q <= 1'b0;
            pc_q       <= adv_pc;
            st_q       <= adv_st;
          end
        end
        S_HALT: begin
        end
        default: st_q <= S_LOAD;
      endcase
    end
  end

  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;
  assign prog_len = len_q;
  assign running  = (st_q == S_FETCH) || (st_q == S_DECODE) ||
                    (st_q == S_ISSUE);
  assign halted   = (st_q == S_HALT);
  assign load_ovf = ovf_q;
  assign bad_jump = bj_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: table of load/run scenarios checked through an
// issue scoreboard, plus directed stall, abort, overflow and reset sequences.
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       state;
  logic       load;
  logic [7:0] instr;
  logic       z_flag;
  logic       ex_ready;
  logic [7:0] ir;
  logic       ir_valid;
  logic [3:0] pc;
  logic [4:0] prog_len;
  logic       running;
  logic       halted;
  logic       load_ovf;
  logic       bad_jump;

  prog_sequencer #(.ADDR_W(4), .INSTR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .load     (load),
    .instr    (instr),
    .z_flag   (z_flag),
    .ex_ready (ex_ready),
    .ir       (ir),
    .ir_valid (ir_valid),
    .pc       (pc),
    .prog_len (prog_len),
    .running  (running),
    .halted   (halted),
    .load_ovf (load_ovf),
    .bad_jump (bad_jump)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    int             n;
    logic [7:0][7:0] prog;
    int             nexp;
    logic [9:0][7:0] seq;
    int             ntk;
    logic [7:0]     zkey;
    logic [3:0]     pc_end;
    logic           bj;
  } vec_t;

  vec_t vt[3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic ld(input logic [7:0] v);
    instr = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic to_load();
    state    = 1'b0;
    ex_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 30; c++) begin
      if (ir_valid) break;
      @(negedge clk);
    end
    chk("valid_seen", ir_valid, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_ir_valid"}, ir_valid, 0);
    chk({tag, "_prog_len"}, prog_len, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_load_ovf"}, load_ovf, 0);
    chk({tag, "_bad_jump"}, bad_jump, 0);
  endtask

  // z_flag goes high once zkey has been accepted more than ntk times
  task automatic run_prog(input int ntk, input logic [7:0] zkey,
                          input logic [3:0] pce, input logic bje);
    int         cnt;
    bit         done;
    logic [7:0] e;
    cnt      = 0;
    done     = 1'b0;
    z_flag   = 1'b0;
    ex_ready = 1'b1;
    state    = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (ir_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_issue: got %0h want none", ir);
        end else begin
          e = exp_q.pop_front();
          chk("issue", ir, e);
        end
        if (ir == zkey) cnt++;
        z_flag = (cnt > ntk);
      end
      if (halted) done = 1'b1;
    end
    chk("halted", halted, 1);
    chk("running", running, 0);
    chk("pc_end", pc, pce);
    chk("bad_jump", bad_jump, bje);
    chk("sb_empty", exp_q.size(), 0);
    ex_ready = 1'b0;
    z_flag   = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    state    = 1'b0;
    load     = 1'b0;
    instr    = '0;
    z_flag   = 1'b0;
    ex_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b1;

    vt[0].n      = 8;
    vt[0].prog   = {8'h00, 8'h06, 8'h34, 8'h07,
                    8'h0D, 8'h41, 8'h2A, 8'h0F};
    vt[0].nexp   = 7;
    vt[0].seq    = {24'h0, 8'h00, 8'h06, 8'h07,
                    8'h0D, 8'h41, 8'h2A, 8'h0F};
    vt[0].ntk    = 0;
    vt[0].zkey   = 8'h07;
    vt[0].pc_end = 4'd7;
    vt[0].bj     = 1'b0;

    vt[1]        = vt[0];
    vt[1].nexp   = 9;
    vt[1].seq    = {8'h0, 8'h00, 8'h06, 8'h07, 8'h07,
                    8'h07, 8'h0D, 8'h41, 8'h2A, 8'h0F};
    vt[1].ntk    = 2;

    vt[2].n      = 2;
    vt[2].prog   = {48'h0, 8'h39, 8'h0A};
    vt[2].nexp   = 1;
    vt[2].seq    = {72'h0, 8'h0A};
    vt[2].ntk    = 1;
    vt[2].zkey   = 8'h0A;
    vt[2].pc_end = 4'd9;
    vt[2].bj     = 1'b1;

    for (int v = 0; v < 3; v++) begin
      to_load();
      chk("len_cleared", prog_len, 0);
      for (int j = 0; j < vt[v].n; j++) ld(vt[v].prog[j]);
      chk("len_loaded", prog_len, vt[v].n);
      chk("ovf_clear", load_ovf, 0);
      for (int j = 0; j < vt[v].nexp; j++) exp_q.push_back(vt[v].seq[j]);
      run_prog(vt[v].ntk, vt[v].zkey, vt[v].pc_end, vt[v].bj);
    end

    // stall in ISSUE, single acceptance, then abort mid-issue
    to_load();
    for (int j = 0; j < 8; j++) ld(vt[0].prog[j]);
    ex_ready = 1'b0;
    state    = 1'b1;
    @(negedge clk);
    wait_valid();
    chk("stall_ir0", ir, 8'h0F);
    ex_ready = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0;
    chk("accept0_valid", ir_valid, 0);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", ir_valid, 1);
      chk("hold_ir", ir, 8'h2A);
      chk("hold_pc", pc, 1);
    end
    ex_ready = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0;
    chk("accept1_valid", ir_valid, 0);
    chk("accept1_pc", pc, 2);
    repeat (2) @(negedge clk);
    chk("next_valid", ir_valid, 1);
    chk("next_ir", ir, 8'h41);
    chk("next_pc", pc, 2);
    state    = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0;
    chk("abort_valid", ir_valid, 0);
    chk("abort_len", prog_len, 0);
    chk("abort_pc", pc, 2);
    chk("abort_running", running, 0);
    chk("abort_halted", halted, 0);
    chk("abort_bj_kept", bad_jump, 1);

    // overflow: 17 loads into a 16-deep store
    for (int j = 0; j < 17; j++) ld(8'(8'h40 + j));
    chk("ovf_len", prog_len, 16);
    chk("ovf_flag", load_ovf, 1);
    for (int j = 0; j < 16; j++) exp_q.push_back(8'(8'h40 + j));
    run_prog(0, 8'hFF, 4'd15, 1'b1);

    // reset in the middle of a run
    to_load();
    ld(8'h0F);
    ld(8'h2A);
    state = 1'b1;
    @(negedge clk);
    wait_valid();
    chk("pre_rst_ir", ir, 8'h0F);
    chk("pre_rst_ovf", load_ovf, 1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    rst   = 1'b1;
    state = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Instruction-store and fetch/issue controller for the 4-bit microcode processor.
- In load mode (state=0) it captures the host instruction stream into a local program store.
- In run mode (state=1) it steps a program counter, fetches and decodes control flow (JNZ), and issues all other instructions to the datapath over a valid/ready handshake.
- Sits between the top-level instr/load/state pins and the datapath's instruction input.

Parameters:
- ADDR_W, 4, program-store address width; depth DEPTH = 2**ADDR_W.
- INSTR_W, 8, instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- state  input  1  mode select: 0 = load, 1 = run.
- load  input  1  write strobe for instr in load mode.
- instr  input  INSTR_W  instruction to store.
- z_flag  input  1  datapath zero flag, sampled at JNZ decode.
- ex_ready  input  1  datapath accepts the issued instruction.
- ir  output  INSTR_W  issued instruction register.
- ir_valid  output  1  ir holds an instruction awaiting acceptance.
- pc  output  ADDR_W  program counter.
- prog_len  output  ADDR_W+1  number of stored instructions.
- running  output  1  FSM is in FETCH, DECODE or ISSUE.
- halted  output  1  run completed or aborted.
- load_ovf  output  1  sticky: a load was dropped because the store was full.
- bad_jump  output  1  sticky: JNZ target >= prog_len.

Behaviour:
- Reset (rst=0 at an edge) sets: pc=0, ir=0, ir_valid=0, prog_len=0, running=0, halted=0, load_ovf=0, bad_jump=0, FSM=LOAD. Program store contents are not reset.
- Decode rule: JNZ is instr[7:4]==4'h3, with target instr[3:0] (zero-extended/truncated to ADDR_W). Every other code is opaque and is issued to the datapath.
- LOAD (state=0):
  - load=1 and prog_len<DEPTH: mem[prog_len]<=instr, prog_len++.
  - load=1 and prog_len==DEPTH: write dropped, load_ovf<=1, prog_len unchanged.
  - load is ignored whenever state=1.
- LOAD->FETCH: edge sampling state=1. pc<=0, halted<=0. If prog_len==0, go to HALT instead.
- FETCH (1 cycle): ir<=mem[pc], then DECODE.
- DECODE (1 cycle):
  - JNZ with z_flag=0: pc<=target; target>=prog_len goes to HALT with bad_jump<=1, otherwise FETCH.
  - JNZ with z_flag=1: fall through as next-pc.
  - Non-JNZ: ir_valid<=1, go to ISSUE.
  - JNZ is never presented on ir_valid.
- ISSUE: ir and ir_valid are held stable until ex_ready=1 at an edge. On that edge ir_valid<=0 and next-pc applies.
- Next-pc: pc+1; if pc+1==prog_len go to HALT (pc holds last address), else FETCH.
- Latency:
  - First ir_valid is high 2 edges after the edge sampling state=1.
  - Back-to-back issue spacing is 3 cycles minimum (ISSUE accept, FETCH, DECODE).
  - A taken JNZ costs 2 cycles.
- HALT: running=0, halted=1. Remains until state=0.
- State 1->0 at any point, including mid-ISSUE:
  - Next edge returns to LOAD, ir_valid<=0, prog_len<=0, halted<=0.
  - Sticky flags are kept. Store contents are kept but considered invalid.
- Reset mid-run behaves exactly as reset above.
- Simultaneous events:
  - ex_ready=1 while ir_valid=0 is ignored.
  - state falling on the same edge as an ex_ready acceptance: abort wins; no pc update is observable.
- running = FSM in {FETCH, DECODE, ISSUE}.

Test Plan:
- Load 0F,2A,41,0D,07,34,06,00 with state=0 -> prog_len=8, load_ovf=0. Run with ex_ready=1 and z_flag=1 -> ir issues 0F,2A,41,0D,07,06,00 in order (JNZ 0x34 never issued); halted=1 with pc=7.
- Same program, z_flag=0 for the first two JNZ decodes, then 1 -> sequence 0F,2A,41,0D,07,07,07,06,00; each taken jump returns pc to 4.
- Hold ex_ready=0 for 5 cycles while ir=2A -> ir_valid stays 1, ir and pc constant. Raising ex_ready gives exactly one acceptance, then pc=2.
- Load 17 instructions with ADDR_W=4 -> prog_len=16, load_ovf=1; mem[15] holds the 16th value.
- Program 0A,39 (JNZ to 9) with z_flag=0 and prog_len=2 -> 0A issued, then halted=1, bad_jump=1, no second issue.
- Drop state to 0 while ir_valid=1 -> ir_valid=0 and prog_len=0 next edge. Assert rst=0 mid-run -> all outputs take reset values on that edge.
